// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the dmem_pipe data memory.
//   RW_B / RW_H / RW_W / RW_ILL : access size encodings in req_type[1:0]
//   RW_U                        : bit of req_type that selects zero-extension
//   resp_state_t                : response register occupancy
//   be_of()                     : byte-enable pattern for a store of a given
//                                 size at a given low address
package dmem_pkg;

    localparam logic [1:0] RW_B   = 2'b00;
    localparam logic [1:0] RW_H   = 2'b01;
    localparam logic [1:0] RW_W   = 2'b10;
    localparam logic [1:0] RW_ILL = 2'b11;

    localparam int RW_U = 2;

    typedef enum logic {
        RESP_EMPTY = 1'b0,
        RESP_FULL  = 1'b1
    } resp_state_t;

    // Half accesses only look at addr_lo[1] so that the same pattern is
    // correct whether or not alignment is being enforced.
    function automatic logic [3:0] be_of(input logic [1:0] rw_type,
                                         input logic [1:0] addr_lo);
        logic [3:0] be;
        be = 4'b0000;
        case (rw_type)
            RW_B:    be = 4'b0001 << addr_lo;
            RW_H:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
            RW_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_pipe_if.sv
// dmem_pipe_if: request/response handshake bundle for the MEM-stage memory.
//   req_valid/req_ready          : request handshake
//   req_we, req_addr, req_type   : store flag, byte address, size + extension
//   req_wdata                    : right-aligned store data
//   resp_valid/resp_ready        : response handshake
//   resp_rdata, resp_err         : extended load data, fault flag
// master = the pipeline stage issuing accesses, slave = the memory.
interface dmem_pipe_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_type;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_type, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_type, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_bram.sv
// dmem_bram: DEPTH x 32 single-port RAM with per-byte write enables and a
// registered read, both on clk. Contents are never reset.
//   clk   : clock
//   addr  : word index shared by read and write
//   be    : byte write enables (bit i writes byte lane i)
//   wdata : lane-replicated write data
//   rd_en : capture mem[addr] into rdata at this edge
//   rdata : registered read data, holds between reads
module dmem_bram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    input  logic          rd_en,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Read data only moves on rd_en so a stalled response keeps its word.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_pipe.sv
// dmem_pipe: handshaked byte/half/word data memory for the MEM stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : dmem_pipe_if.slave (request in, one response per accepted
//                request one cycle later, held under backpressure)
// Faulting accesses (out of range, misaligned, illegal size) never write
// and answer with resp_err=1, resp_rdata=0.
module dmem_pipe
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int AW          = $clog2(DEPTH),
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    dmem_pipe_if.slave  bus
);

    resp_state_t   state;
    resp_state_t   state_next;
    logic          accept;
    logic [1:0]    size;
    logic          out_of_range;
    logic          misaligned;
    logic          illegal;
    logic          req_err;
    logic [AW-1:0] word_idx;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;
    logic [31:0]   ram_rdata;

    logic          err_q;
    logic          ld_q;
    logic [1:0]    lo_q;
    logic [2:0]    type_q;

    logic [7:0]    byte_lane;
    logic [15:0]   half_lane;
    logic [31:0]   load_ext;

    assign size         = bus.req_type[1:0];
    assign word_idx     = bus.req_addr[AW+1:2];
    assign out_of_range = |bus.req_addr[31:AW+2];
    assign illegal      = (size == RW_ILL);

    // A new request can enter whenever the response slot is free or is
    // being drained in the same cycle.
    assign bus.req_ready  = (state == RESP_EMPTY) || bus.resp_ready;
    assign accept         = bus.req_valid && bus.req_ready;
    assign bus.resp_valid = (state == RESP_FULL);

    // Alignment faults are only raised when enforcement is enabled;
    // otherwise the lane logic simply ignores the unused low bits.
    always_comb begin
        misaligned = 1'b0;
        if (CHECK_ALIGN) begin
            if (size == RW_H) begin
                misaligned = bus.req_addr[0];
            end else if (size == RW_W) begin
                misaligned = |bus.req_addr[1:0];
            end
        end
    end

    assign req_err = out_of_range || misaligned || illegal;

    // Replicate store data across lanes so the byte enables pick the
    // right copy without any shifting.
    always_comb begin
        wr_data = bus.req_wdata;
        case (size)
            RW_B:    wr_data = {4{bus.req_wdata[7:0]}};
            RW_H:    wr_data = {2{bus.req_wdata[15:0]}};
            default: wr_data = bus.req_wdata;
        endcase
    end

    assign wr_be = (accept && bus.req_we && !req_err)
                 ? be_of(size, bus.req_addr[1:0]) : 4'b0000;

    dmem_bram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_bram (
        .clk   (clk),
        .addr  (word_idx),
        .be    (wr_be),
        .wdata (wr_data),
        .rd_en (accept && !bus.req_we),
        .rdata (ram_rdata)
    );

    // Response slot occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESP_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Slot fills on every accept (replacing a drained response), empties
    // when drained with nothing new arriving.
    always_comb begin
        state_next = state;
        case (state)
            RESP_EMPTY: if (accept) state_next = RESP_FULL;
            RESP_FULL: begin
                if (accept) begin
                    state_next = RESP_FULL;
                end else if (bus.resp_ready) begin
                    state_next = RESP_EMPTY;
                end
            end
            default: state_next = RESP_EMPTY;
        endcase
    end

    // Per-response metadata captured alongside the RAM read so lane
    // selection can be done on the registered word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q  <= 1'b0;
            ld_q   <= 1'b0;
            lo_q   <= 2'b00;
            type_q <= 3'b000;
        end else if (accept) begin
            err_q  <= req_err;
            ld_q   <= !bus.req_we && !req_err;
            lo_q   <= bus.req_addr[1:0];
            type_q <= bus.req_type;
        end
    end

    // Lane select and sign/zero extension of the registered word.
    always_comb begin
        byte_lane = ram_rdata[{lo_q, 3'b000} +: 8];
        half_lane = lo_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        load_ext  = ram_rdata;
        case (type_q[1:0])
            RW_B:    load_ext = {{24{~type_q[RW_U] & byte_lane[7]}}, byte_lane};
            RW_H:    load_ext = {{16{~type_q[RW_U] & half_lane[15]}}, half_lane};
            default: load_ext = ram_rdata;
        endcase
    end

    // Stores and faults answer with zero data.
    assign bus.resp_rdata = ld_q ? load_ext : 32'h0000_0000;
    assign bus.resp_err   = err_q;

endmodule

// File: doc/dmem_pipe.md
# dmem_pipe

Parametrised, handshaked data memory for the RISC-V core's MEM stage. It supports byte, half and word loads and stores, with sign or zero extension on loads, and uses per-byte write enables instead of read-modify-write. Read data is registered, so every load or store returns one response one cycle after acceptance, through a one-entry response register with backpressure. Misaligned, out-of-range and illegal-type accesses are reported as errors and never modify memory.

## Interface
Parameters:
- `DEPTH`, 1024: number of 32-bit words. Must be a power of two, at least 4.
- `AW`, $clog2(DEPTH): word-index width.
- `CHECK_ALIGN`, 1: when 1, misaligned accesses set `resp_err`. When 0, low address bits are ignored: half uses addr[1], word uses neither.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted this cycle when both `req_valid` and `req_ready` are high.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_type` in 3: RW_type encoding.
  - [1:0]: 00 byte, 01 half, 10 word, 11 illegal.
  - [2]: 1 = zero-extend, 0 = sign-extend (loads only).
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: response consumed when both `resp_valid` and `resp_ready` are high.
- `resp_rdata` out 32: extended load data. 0 for stores and errors.
- `resp_err` out 1: access faulted; no write occurred.

## Operation
- `req_ready = !resp_valid || resp_ready` (combinational). Accept = `req_valid && req_ready`.
- Word index = req_addr[AW+1:2].
- Out-of-range: any of req_addr[31:AW+2] nonzero -> error.
- Misaligned (only when CHECK_ALIGN=1) -> error:
  - half with addr[0] = 1;
  - word with addr[1:0] != 0.
- Type 11 -> error.
- Store accepted without error: write byte enables at the accept edge.
  - byte: be = 1 << addr[1:0], lane data = wdata[7:0] replicated.
  - half: be = addr[1] ? 4'b1100 : 4'b0011, lane data = wdata[15:0] replicated.
  - word: be = 4'b1111.
- Load accepted without error:
  - the RAM word is read synchronously at the accept edge;
  - the lane is selected by addr[1:0] or addr[1];
  - the lane is extended per req_type[2];
  - the result is registered into `resp_rdata`.
- Every accepted request, error or not, produces exactly one response.
- Response register states: EMPTY (resp_valid=0) and FULL (resp_valid=1).
  - EMPTY -> FULL on accept.
  - FULL -> FULL on accept together with `resp_ready` (back-to-back; the new response replaces the old one).
  - FULL -> EMPTY on `resp_ready` without accept.
  - While FULL and `resp_ready` is 0: `req_ready` = 0 and the response fields hold stable.
- A store followed by a load to the same word in the next accepted cycle returns the stored data. The write commits at the earlier edge, so no forwarding is needed.
- RAM contents are not reset.

## Timing
- Reset (asynchronous assert, synchronous release): `resp_valid`=0, `resp_rdata`=0, `resp_err`=0. `req_ready` becomes 1 as a consequence.
- Latency: accept at edge N -> `resp_valid` high after edge N, consumable in cycle N+1.
- Throughput: one request per cycle while `resp_ready`=1.
- Reset asserted mid-operation: the pending response is discarded. A store whose accept edge already passed remains written.
- A `resp_ready` that arrives while `resp_valid`=0 is ignored.

## Structure
- Package `dmem_pkg`:
  - RW_type constants: `RW_B`=2'b00, `RW_H`=2'b01, `RW_W`=2'b10;
  - `RW_U` bit index 2;
  - a function `be_of(type, addr_lo)` returning the 4-bit byte enable.
- Sub-module `dmem_bram`: DEPTH x 32 array with 4-bit byte-enable write and synchronous read port, both on `clk`. Lane selection and extension stay in `dmem_pipe`.

## Test plan
- Store word 0xDEADBEEF at 0x10, then load word 0x10 -> resp_rdata 0xDEADBEEF, err 0, response one cycle after accept.
- Store byte 0x7F at 0x11, then:
  - signed byte load at 0x11 -> 0x0000007F;
  - word load at 0x10 -> 0xDEAD7FEF.
  - Then store byte 0x80 at 0x13 and do a signed byte load at 0x13 -> 0xFFFFFF80.
- Store half 0x8001 at 0x12, then:
  - signed half load at 0x12 -> 0xFFFF8001;
  - unsigned half load at 0x12 -> 0x00008001.
- Errors, each giving err 1, rdata 0, and a following word load at 0x10 unchanged:
  - word store at 0x12;
  - half load at 0x11;
  - type 11;
  - address (DEPTH*4).
- Backpressure: hold resp_ready=0 with 3 back-to-back requests -> req_ready drops after the first accept, the first response is held stable, and releasing resp_ready drains all 3 in order.
- Assert rst_n mid-stream while resp_valid=1 -> resp_valid, resp_rdata and resp_err go to 0 immediately, and previously written data is still readable after release.
